// File: rtl/host_port_arbiter.sv
// host_port_arbiter: round-robin sharing of one LSU-style host port with in-order response routing
// Ports: clk_i/rst_ni clock and sync active-low reset; req_i/gnt_o/addr_i/we_i/wdata_i/be_i requester
// command side; rvalid_o/rdata_o/err_o/intg_err_o requester response side; req_o/gnt_i/addr_o/we_o/
// wdata_o/be_o downstream command; valid_i/rdata_i/err_i/intg_err_i downstream response;
// outstanding_o ID FIFO occupancy; spurious_o sticky unexpected-response flag.
module host_port_arbiter #(
   parameter int NumReq         = 2,
   parameter int MaxOutstanding = 2
) (
   input  logic                                clk_i,
   input  logic                                rst_ni,
   input  logic [NumReq-1:0]                   req_i,
   output logic [NumReq-1:0]                   gnt_o,
   input  logic [NumReq*32-1:0]                addr_i,
   input  logic [NumReq-1:0]                   we_i,
   input  logic [NumReq*32-1:0]                wdata_i,
   input  logic [NumReq*4-1:0]                 be_i,
   output logic [NumReq-1:0]                   rvalid_o,
   output logic [31:0]                         rdata_o,
   output logic                                err_o,
   output logic                                intg_err_o,
   output logic                                req_o,
   input  logic                                gnt_i,
   output logic [31:0]                         addr_o,
   output logic                                we_o,
   output logic [31:0]                         wdata_o,
   output logic [3:0]                          be_o,
   input  logic                                valid_i,
   input  logic [31:0]                         rdata_i,
   input  logic                                err_i,
   input  logic                                intg_err_i,
   output logic [$clog2(MaxOutstanding+1)-1:0] outstanding_o,
   output logic                                spurious_o
);
   localparam int IW = (NumReq > 1) ? $clog2(NumReq) : 1;
   localparam int PW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
   localparam int CW = $clog2(MaxOutstanding + 1);
   typedef enum logic {UNLOCKED, LOCKED} state_e;
   state_e state_q, state_d;
   logic [IW-1:0] owner_q, owner_d, rr_q, arb, sel, sel_nxt;
   logic [IW-1:0] id_q [MaxOutstanding];
   logic [PW-1:0] wr_q, rd_q;
   logic [CW-1:0] count_q;
   logic [IW:0]   cand;
   logic          spurious_q, found, room, hs, pop;
   // first requester at or after rr_q, wrapping around
   always_comb begin
      arb = '0;
      found = 1'b0;
      cand = '0;
      for (int i = 0; i < NumReq; i++) begin
         cand = {1'b0, rr_q} + (IW+1)'(i);
         cand = (cand >= (IW+1)'(NumReq)) ? cand - (IW+1)'(NumReq) : cand;
         if (!found && req_i[cand[IW-1:0]]) begin
            arb = cand[IW-1:0];
            found = 1'b1;
         end
      end
   end
   assign sel        = (state_q == LOCKED) ? owner_q : arb;
   assign sel_nxt    = (sel == IW'(NumReq - 1)) ? '0 : sel + 1'b1;
   assign room       = count_q < CW'(MaxOutstanding);
   assign req_o      = rst_ni && req_i[sel] && room;
   assign hs         = req_o && gnt_i;
   assign pop        = rst_ni && valid_i && (count_q != '0);
   assign addr_o     = req_o ? addr_i[{sel, 5'b0} +: 32] : '0;
   assign wdata_o    = req_o ? wdata_i[{sel, 5'b0} +: 32] : '0;
   assign be_o       = req_o ? be_i[{sel, 2'b0} +: 4] : '0;
   assign we_o       = req_o && we_i[sel];
   assign gnt_o      = hs ? NumReq'(1) << sel : '0;
   assign rvalid_o   = pop ? NumReq'(1) << id_q[rd_q] : '0;
   assign rdata_o    = pop ? rdata_i : '0;
   assign err_o      = pop && err_i;
   assign intg_err_o = pop && intg_err_i;
   assign outstanding_o = rst_ni ? count_q : '0;
   assign spurious_o = rst_ni && spurious_q;
   // an unanswered request pins the owner until the downstream grant arrives
   always_comb begin
      state_d = hs ? UNLOCKED : req_o ? LOCKED : state_q;
      owner_d = (req_o && !hs) ? sel : owner_q;
   end
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q    <= UNLOCKED;
         owner_q    <= '0;
         rr_q       <= '0;
         wr_q       <= '0;
         rd_q       <= '0;
         count_q    <= '0;
         spurious_q <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         if (hs) rr_q <= sel_nxt;
         if (hs) wr_q <= (wr_q == PW'(MaxOutstanding - 1)) ? '0 : wr_q + 1'b1;
         if (pop) rd_q <= (rd_q == PW'(MaxOutstanding - 1)) ? '0 : rd_q + 1'b1;
         count_q <= count_q + CW'(hs) - CW'(pop);
         if (valid_i && count_q == '0) spurious_q <= 1'b1;
      end
   end
   always_ff @(posedge clk_i) begin
      if (hs) id_q[wr_q] <= sel;
   end
   assert property (@(posedge clk_i) disable iff (!rst_ni) (state_q == LOCKED) |-> req_i[owner_q]);
endmodule

// File: tb/tb_host_port_arbiter.sv
// tb_host_port_arbiter: randomized bench comparing host_port_arbiter against a queue-based reference model
module tb_host_port_arbiter;
   localparam int N = 2;
   localparam int M = 2;
   logic clk = 1'b0;
   logic rst_n;
   logic [N-1:0] req, gnt_o, rvalid;
   logic [N*32-1:0] addr, wdata;
   logic [N-1:0] we;
   logic [N*4-1:0] be;
   logic [31:0] rdata_o, addr_o, wdata_o, rdata;
   logic err_o, intg_err_o, req_o, gnt, we_o, valid, err, intg_err, spurious;
   logic [3:0] be_o;
   logic [$clog2(M+1)-1:0] outstanding;
   logic [31:0] a [N];
   logic [31:0] d [N];
   logic [3:0] b [N];
   logic w [N];
   bit granted [N];
   int owner, rr, checks, errors;
   int q [$];
   bit spur;
   always #5 clk = ~clk;
   host_port_arbiter #(.NumReq(N), .MaxOutstanding(M)) dut (
      .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt_o), .addr_i(addr), .we_i(we),
      .wdata_i(wdata), .be_i(be), .rvalid_o(rvalid), .rdata_o(rdata_o), .err_o(err_o),
      .intg_err_o(intg_err_o), .req_o(req_o), .gnt_i(gnt), .addr_o(addr_o), .we_o(we_o),
      .wdata_o(wdata_o), .be_o(be_o), .valid_i(valid), .rdata_i(rdata), .err_i(err),
      .intg_err_i(intg_err), .outstanding_o(outstanding), .spurious_o(spurious)
   );
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         if (errors <= 20) $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
      end
   endtask
   task automatic compare(input int gx, input bit rx, input logic [31:0] ax, input bit wx,
                          input logic [31:0] dx, input logic [3:0] bx, input int vx,
                          input logic [31:0] rdx, input bit ex, input bit ix, input int ox, input bit sx);
      check("gnt_o", gnt_o, gx);
      check("req_o", req_o, rx);
      check("addr_o", addr_o, ax);
      check("we_o", we_o, wx);
      check("wdata_o", wdata_o, dx);
      check("be_o", be_o, bx);
      check("rvalid_o", rvalid, vx);
      check("rdata_o", rdata_o, rdx);
      check("err_o", err_o, ex);
      check("intg_err_o", intg_err_o, ix);
      check("outstanding_o", outstanding, ox);
      check("spurious_o", spurious, sx);
   endtask
   task automatic eval();
      int sel, sz, k;
      bit rx, hs, pop;
      if (!rst_n) begin
         compare(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
         owner = -1;
         rr = 0;
         q.delete();
         spur = 0;
         return;
      end
      sel = owner;
      if (sel < 0)
         for (int i = 0; i < N; i++) begin
            k = (rr + i) % N;
            if (sel < 0 && req[k]) sel = k;
         end
      sz = q.size();
      rx = sel >= 0 && req[sel] && sz < M;
      hs = rx && gnt;
      pop = valid && sz > 0;
      compare(hs ? (1 << sel) : 0, rx, rx ? a[sel] : 0, rx && w[sel], rx ? d[sel] : 0,
              rx ? b[sel] : 4'h0, pop ? (1 << q[0]) : 0, pop ? rdata : 0,
              pop && err, pop && intg_err, sz, spur);
      if (pop) void'(q.pop_front());
      if (hs) begin
         owner = -1;
         rr = (sel + 1) % N;
         q.push_back(sel);
         granted[sel] = 1;
      end else if (rx) owner = sel;
      if (valid && sz == 0) spur = 1;
   endtask
   initial begin
      int pg, pv, ps, ph;
      checks = 0;
      errors = 0;
      rst_n = 0;
      req = '0; addr = '0; wdata = '0; we = '0; be = '0;
      gnt = 0; valid = 0; rdata = '0; err = 0; intg_err = 0;
      for (int k = 0; k < N; k++) begin
         a[k] = '0; d[k] = '0; b[k] = '0; w[k] = 0; granted[k] = 0;
      end
      @(posedge clk);
      @(negedge clk);
      eval();
      for (int c = 0; c < 4000; c++) begin
         @(posedge clk);
         #1;
         ph = (c / 400) % 4;
         pg = (ph == 1) ? 20 : 75;
         pv = (ph == 2) ? 10 : 50;
         ps = (ph == 3) ? 15 : 0;
         rst_n = (c % 617 != 300);
         for (int k = 0; k < N; k++) begin
            if (granted[k]) begin
               req[k] = 0;
               granted[k] = 0;
            end
            if (!req[k] && $urandom_range(99) < 60) begin
               req[k] = 1;
               a[k] = $urandom;
               d[k] = $urandom;
               b[k] = 4'($urandom);
               w[k] = 1'($urandom);
            end
            addr[32*k +: 32] = a[k];
            wdata[32*k +: 32] = d[k];
            be[4*k +: 4] = b[k];
            we[k] = w[k];
         end
         gnt = $urandom_range(99) < pg;
         valid = $urandom_range(99) < ((q.size() > 0) ? pv : ps);
         rdata = $urandom;
         err = 1'($urandom);
         intg_err = 1'($urandom);
         @(negedge clk);
         eval();
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
